mic_mem_responder: RTL and testbench
====================================

Name: mic_mem_responder

Overview:
- Memory-side responder for the MIC-1 datapath's two memory ports.
- Word port: 32-bit, word-addressed, driven from MAR/MDR, read and write.
- Byte port: 8-bit, byte-addressed, driven from PC, fetch only; returns one byte for MBR.
- Both ports share a single-port backing array, so the block arbitrates between them and returns fixed-latency responses to the datapath.

Parameters:
ADDR_W, 10, word-address bits used; array depth = 2**ADDR_W words of 32 bits

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
mar  in  32  word address; only mar[ADDR_W-1:0] is used
mdr_wdata  in  32  write data, sampled with mem_wr
mem_rd  in  1  word read request
mem_wr  in  1  word write request
mdr_rdata  out  32  word read data for MDR
mdr_valid  out  1  one-cycle pulse; mdr_rdata is new this cycle
pc  in  32  byte address; pc[ADDR_W+1:2] selects the word, pc[1:0] selects the byte
fetch  in  1  byte fetch request
mbr_rdata  out  8  fetched byte for MBR
mbr_valid  out  1  one-cycle pulse; mbr_rdata is new this cycle
err_rdwr  out  1  one-cycle pulse: mem_rd and mem_wr were both sampled high
err_fovf  out  1  one-cycle pulse: a fetch was dropped

Behaviour:
- Reset (async, rst_n=0):
  - mdr_rdata=0, mdr_valid=0, mbr_rdata=0, mbr_valid=0, err_rdwr=0, err_fovf=0.
  - Pending-fetch slot cleared; in-flight reads squashed, so no valid pulses follow release.
  - Array contents are not reset.
- Edge naming: E0 is the edge where a request is sampled; E1 and E2 are the following edges.
- Word read:
  - Array read at E0 into an internal stage register.
  - At E1, mdr_rdata is loaded and mdr_valid=1 for the cycle E1..E2.
  - The datapath can capture the data at E2, i.e. two cycles after issue, matching MIC-1 timing.
  - Back-to-back reads on every edge are fully pipelined, one response per cycle, in order.
- Word write: array[mar] <= mdr_wdata at E0. No response pulse.
- Read-after-write: a read sampled at E1 after a write at E0 returns the new data.
- mem_rd and mem_wr both high:
  - Treated as a write only; no read response.
  - err_rdwr=1 for the cycle E1..E2.
- Arbitration: one array access per edge. Priority: word request, then pending fetch, then new fetch.
- Fetch with no conflict:
  - Array read at E0; at E1, mbr_rdata is loaded and mbr_valid=1 for one cycle.
  - Byte select is big-endian: pc[1:0]=0 gives word[31:24], 1 gives [23:16], 2 gives [15:8], 3 gives [7:0].
- Fetch colliding with a word request at E0:
  - Fetch address is latched into the pending slot.
  - It is serviced at the first later edge with no word request.
  - mbr_valid follows one edge after service.
  - A deferred fetch sees any write committed before it is serviced.
- Fetch arriving while the slot is occupied:
  - If the slot is serviced at that edge, the new fetch goes into the slot.
  - Otherwise the new fetch is dropped and err_fovf=1 for one cycle.
- Word reads and fetches complete independently; mdr_valid and mbr_valid may be high in the same cycle.
- mdr_rdata and mbr_rdata hold their last value between valid pulses.
- Addresses wrap modulo the depth: upper bits are ignored with no error. Example: mar=0x400 with ADDR_W=10 accesses word 0.
- Reset asserted mid-operation drops all outstanding work immediately. After release, the first request behaves as from idle.

Test Plan:
- Write mar=5, data 0xDEADBEEF at E0; read mar=5 at E1 -> mdr_valid high E2..E3 with mdr_rdata=0xDEADBEEF.
- Reads of mar=1,2,3 on consecutive edges (array preloaded 0x11,0x22,0x33) -> three consecutive mdr_valid cycles returning 0x11, 0x22, 0x33 in order.
- Word 2 = 0xA1B2C3D4; fetch pc=8,9,10,11 on consecutive edges -> mbr_rdata 0xA1, 0xB2, 0xC3, 0xD4, one per cycle, each one edge after its request.
- Fetch pc=8 together with write mar=2 data 0x01020304; idle next edge -> fetch deferred one edge, then mbr_rdata=0x01 (new data); mbr_valid one edge later than the uncontended case.
- Fetch blocked by word reads on 3 consecutive edges, with a second fetch on the next edge -> err_fovf pulses once; only the first fetch returns.
- mem_rd=mem_wr=1 at mar=7, data 0x55 -> err_rdwr pulse, no mdr_valid, later read of 7 returns 0x55.
- rst_n low one cycle after a read issue -> no mdr_valid, all outputs 0.

Source files
------------

// File: rtl/mic_mem_responder.sv
// MIC-1 memory responder: a 32-bit word port (MAR/MDR, read/write) and an
// 8-bit fetch port (PC/MBR) sharing one single-port array. Word requests
// win the array; a fetch that loses is parked in a one-entry slot and
// serviced on the next edge with no word request. All responses appear
// one edge after the array access.
module mic_mem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mar,
    input  logic [31:0] mdr_wdata,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic [31:0] mdr_rdata,
    output logic        mdr_valid,
    input  logic [31:0] pc,
    input  logic        fetch,
    output logic [7:0]  mbr_rdata,
    output logic        mbr_valid,
    output logic        err_rdwr,
    output logic        err_fovf
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       arr_rdata_q;

    logic              word_req;
    logic              rd_issue;
    logic              byte_issue;
    logic [ADDR_W-1:0] acc_addr;

    logic              slot_valid_d, slot_valid_q;
    logic [ADDR_W+1:0] slot_addr_d,  slot_addr_q;
    logic              fovf_d;
    logic [1:0]        byte_sel_d,   byte_sel_q;
    logic              word_stage_q;
    logic              byte_stage_q;
    logic              rdwr_stage_q;
    logic              fovf_stage_q;

    logic [31:0]       mdr_rdata_d,  mdr_rdata_q;
    logic [7:0]        mbr_rdata_d,  mbr_rdata_q;
    logic [7:0]        byte_pick;

    // Address bits above the array depth are intentionally ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mar[31:ADDR_W], pc[31:ADDR_W+2]};

    // Arbitrate the single array port: word request, then parked fetch, then new fetch.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        word_req     = mem_rd | mem_wr;
        rd_issue     = mem_rd & ~mem_wr;
        acc_addr     = mar[ADDR_W-1:0];
        byte_issue   = 1'b0;
        byte_sel_d   = pc[1:0];
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        fovf_d       = 1'b0;

        if (word_req) begin
            if (fetch) begin
                if (slot_valid_q) begin
                    fovf_d = 1'b1;
                end else begin
                    slot_valid_d = 1'b1;
                    slot_addr_d  = pc[ADDR_W+1:0];
                end
            end
        end else if (slot_valid_q) begin
            // Parked fetch takes the port; a new fetch refills the freed slot.
            acc_addr     = slot_addr_q[ADDR_W+1:2];
            byte_sel_d   = slot_addr_q[1:0];
            byte_issue   = 1'b1;
            slot_valid_d = fetch;
            slot_addr_d  = pc[ADDR_W+1:0];
        end else if (fetch) begin
            acc_addr   = pc[ADDR_W+1:2];
            byte_issue = 1'b1;
        end
    end

    // Single-port array: write or read at the arbitrated address each edge.
    // NOTE: the array and its read register carry no reset; contents survive
    // reset and staying reset-free keeps the array mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[acc_addr] <= mdr_wdata;
        end else begin
            arr_rdata_q <= mem_q[acc_addr];
        end
    end

    // Big-endian byte select and hold-last-value output data.
    always_comb begin
        byte_pick = arr_rdata_q[31 - 8*int'(byte_sel_q) -: 8];
        mdr_rdata_d = word_stage_q ? arr_rdata_q : mdr_rdata_q;
        mbr_rdata_d = byte_stage_q ? byte_pick   : mbr_rdata_q;
    end

    // Control pipeline and registered outputs; reset squashes in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= 1'b0;
            slot_addr_q  <= '0;
            byte_sel_q   <= 2'd0;
            word_stage_q <= 1'b0;
            byte_stage_q <= 1'b0;
            rdwr_stage_q <= 1'b0;
            fovf_stage_q <= 1'b0;
            mdr_rdata_q  <= '0;
            mbr_rdata_q  <= '0;
            mdr_valid    <= 1'b0;
            mbr_valid    <= 1'b0;
            err_rdwr     <= 1'b0;
            err_fovf     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            byte_sel_q   <= byte_sel_d;
            word_stage_q <= rd_issue;
            byte_stage_q <= byte_issue;
            rdwr_stage_q <= mem_rd & mem_wr;
            fovf_stage_q <= fovf_d;
            mdr_rdata_q  <= mdr_rdata_d;
            mbr_rdata_q  <= mbr_rdata_d;
            mdr_valid    <= word_stage_q;
            mbr_valid    <= byte_stage_q;
            err_rdwr     <= rdwr_stage_q;
            err_fovf     <= fovf_stage_q;
        end
    end

    assign mdr_rdata = mdr_rdata_q;
    assign mbr_rdata = mbr_rdata_q;

endmodule

// File: tb/tb_mic_mem_responder.sv
// Scoreboard bench for mic_mem_responder. The stimulus side feeds a
// behavioural model that pushes expected (cycle, data) responses; a
// separate monitor pops and compares whenever the DUT raises a pulse.
module tb_mic_mem_responder;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mar, mdr_wdata, pc;
    logic        mem_rd, mem_wr, fetch;
    logic [31:0] mdr_rdata;
    logic        mdr_valid;
    logic [7:0]  mbr_rdata;
    logic        mbr_valid;
    logic        err_rdwr, err_fovf;

    mic_mem_responder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mar       (mar),
        .mdr_wdata (mdr_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mdr_rdata (mdr_rdata),
        .mdr_valid (mdr_valid),
        .pc        (pc),
        .fetch     (fetch),
        .mbr_rdata (mbr_rdata),
        .mbr_valid (mbr_valid),
        .err_rdwr  (err_rdwr),
        .err_fovf  (err_fovf)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t mdr_exp[$];
    exp_t mbr_exp[$];
    int   rdwr_exp[$];
    int   fovf_exp[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] model_mem [1 << AW];
    bit          pend_valid = 1'b0;
    logic [31:0] pend_pc;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
        logic [31:0] sh;
        sh = w >> (8 * (3 - int'(s)));
        return sh[7:0];
    endfunction

    function automatic logic [31:0] fetch_byte(input logic [31:0] p);
        return {24'h0, byte_of(model_mem[p[AW+1:2]], p[1:0])};
    endfunction

    // Apply the responder's rules for one sampling edge e; responses are due at e+1.
    task automatic model_step(input logic rd, input logic wr, input logic [31:0] m,
                              input logic [31:0] wd, input logic f, input logic [31:0] p);
        int e;
        bit word_busy;
        e = cyc + 1;
        word_busy = rd | wr;
        if (wr) begin
            model_mem[m[AW-1:0]] = wd;
            if (rd) rdwr_exp.push_back(e + 1);
        end else if (rd) begin
            mdr_exp.push_back('{e + 1, model_mem[m[AW-1:0]]});
        end
        if (word_busy) begin
            if (f) begin
                if (pend_valid) fovf_exp.push_back(e + 1);
                else begin
                    pend_valid = 1'b1;
                    pend_pc    = p;
                end
            end
        end else if (pend_valid) begin
            mbr_exp.push_back('{e + 1, fetch_byte(pend_pc)});
            pend_valid = f;
            pend_pc    = p;
        end else if (f) begin
            mbr_exp.push_back('{e + 1, fetch_byte(p)});
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] m,
                         input logic [31:0] wd, input logic f, input logic [31:0] p);
        @(negedge clk);
        mem_rd    = rd;
        mem_wr    = wr;
        mar       = m;
        mdr_wdata = wd;
        fetch     = f;
        pc        = p;
        model_step(rd, wr, m, wd, f, p);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    int   mon_c;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mdr_valid) begin
                if (mdr_exp.size() == 0) check("mdr_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = mdr_exp.pop_front();
                    check("mdr_cycle", cyc, mon_e.cyc);
                    check("mdr_data", mdr_rdata, mon_e.data);
                end
            end
            if (mbr_valid) begin
                if (mbr_exp.size() == 0) check("mbr_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = mbr_exp.pop_front();
                    check("mbr_cycle", cyc, mon_e.cyc);
                    check("mbr_data", {24'h0, mbr_rdata}, mon_e.data);
                end
            end
            if (err_rdwr) begin
                if (rdwr_exp.size() == 0) check("rdwr_unexpected", 32'd1, 32'd0);
                else begin
                    mon_c = rdwr_exp.pop_front();
                    check("rdwr_cycle", cyc, mon_c);
                end
            end
            if (err_fovf) begin
                if (fovf_exp.size() == 0) check("fovf_unexpected", 32'd1, 32'd0);
                else begin
                    mon_c = fovf_exp.pop_front();
                    check("fovf_cycle", cyc, mon_c);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mdr_rdata"}, mdr_rdata, 32'h0);
        check({tag, "_mdr_valid"}, {31'h0, mdr_valid}, 32'h0);
        check({tag, "_mbr_rdata"}, {24'h0, mbr_rdata}, 32'h0);
        check({tag, "_mbr_valid"}, {31'h0, mbr_valid}, 32'h0);
        check({tag, "_err_rdwr"},  {31'h0, err_rdwr},  32'h0);
        check({tag, "_err_fovf"},  {31'h0, err_fovf},  32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; fetch = 1'b0;
        mar = '0; mdr_wdata = '0; pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Preload the small working set so every read has defined data.
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, i, $urandom, 1'b0, 32'h0);

        // Read-after-write on consecutive edges.
        drive(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 32'h0);
        idle(); idle();

        // Back-to-back pipelined reads.
        drive(1'b0, 1'b1, 32'd1, 32'h11, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'd2, 32'h22, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'd3, 32'h33, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'd1, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'd2, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 32'h0);
        idle(); idle();

        // Big-endian byte fetches from one word.
        drive(1'b0, 1'b1, 32'd2, 32'hA1B2C3D4, 1'b0, 32'h0);
        idle();
        for (int i = 8; i < 12; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, i);
        idle(); idle();

        // Fetch colliding with a write to the same word sees the new data.
        drive(1'b0, 1'b1, 32'd2, 32'h01020304, 1'b1, 32'd8);
        idle(); idle(); idle();

        // Fetch blocked three edges; a second fetch while parked is dropped.
        drive(1'b1, 1'b0, 32'd1, 32'h0, 1'b1, 32'd12);
        drive(1'b1, 1'b0, 32'd2, 32'h0, 1'b1, 32'd16);
        drive(1'b1, 1'b0, 32'd3, 32'h0, 1'b0, 32'h0);
        idle(); idle(); idle();

        // Simultaneous read and write acts as a write and flags an error.
        drive(1'b1, 1'b1, 32'd7, 32'h55, 1'b0, 32'h0);
        idle();
        drive(1'b1, 1'b0, 32'd7, 32'h0, 1'b0, 32'h0);
        idle(); idle();

        // Address wrap: upper bits ignored on both ports.
        drive(1'b0, 1'b1, 32'h405, 32'hCAFEF00D, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h5, 32'h0, 1'b1, 32'h1014);
        idle(); idle(); idle();

        // Randomised traffic over the working set with wrapped upper bits.
        for (int i = 0; i < 400; i++) begin
            logic        r, w, f;
            logic [31:0] m, p;
            r = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 1) == 1);
            m = ($urandom_range(0, 3) == 0) ? (($urandom & 32'hFFFF_FC00) | $urandom_range(0, 15))
                                            : $urandom_range(0, 15);
            p = ($urandom_range(0, 3) == 0) ? (($urandom & 32'hFFFF_F000) | $urandom_range(0, 63))
                                            : $urandom_range(0, 63);
            drive(r, w, m, $urandom, f, p);
        end
        repeat (4) idle();

        // Reset one cycle after a read issue squashes the response.
        drive(1'b1, 1'b0, 32'd5, 32'h0, 1'b1, 32'd4);
        @(negedge clk);
        rst_n = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; fetch = 1'b0;
        mdr_exp.delete(); mbr_exp.delete(); rdwr_exp.delete(); fovf_exp.delete();
        pend_valid = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();

        // First request after release behaves as from idle.
        drive(1'b1, 1'b0, 32'd5, 32'h0, 1'b1, 32'd20);
        repeat (5) idle();

        check("mdr_queue_empty",  mdr_exp.size(),  32'd0);
        check("mbr_queue_empty",  mbr_exp.size(),  32'd0);
        check("rdwr_queue_empty", rdwr_exp.size(), 32'd0);
        check("fovf_queue_empty", fovf_exp.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
